// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, fetches a whole line one word per request
// and streams returned words into the data array, writing the tag with the last word.
module cache_fill_fsm #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_detected,
    input  logic [ADDR_W-1:0]             miss_address,
    output logic                          fsm_busy,
    output logic                          mem_read_en,
    output logic [ADDR_W-1:0]             memory_address,
    input  logic                          memory_data_valid,
    input  logic [15:0]                   memory_data,
    output logic                          write_data_array,
    output logic [$clog2(LINE_WORDS)-1:0] fill_word_index,
    output logic [15:0]                   fill_data,
    output logic                          write_tag_array,
    output logic [ADDR_W-1:0]             fill_base_addr
);

    localparam int unsigned IdxW = $clog2(LINE_WORDS);
    localparam int unsigned CntW = IdxW + 1;
    localparam int unsigned OffW = IdxW + 1;

    localparam logic [ADDR_W-1:0] AlignMask = {ADDR_W{1'b1}} << OffW;

    typedef enum logic [0:0] {
        StIdle,
        StFill
    } stateT;

    stateT             stateQ, stateD;
    logic [CntW-1:0]   reqCntQ, reqCntD;
    logic [CntW-1:0]   retCntQ, retCntD;
    logic [ADDR_W-1:0] baseQ, baseD;
    logic [ADDR_W-1:0] addrQ, addrD;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= StIdle;
            reqCntQ <= '0;
            retCntQ <= '0;
            baseQ   <= '0;
            addrQ   <= '0;
        end else begin
            stateQ  <= stateD;
            reqCntQ <= reqCntD;
            retCntQ <= retCntD;
            baseQ   <= baseD;
            addrQ   <= addrD;
        end
    end

    always_comb begin
        stateD           = stateQ;
        reqCntD          = reqCntQ;
        retCntD          = retCntQ;
        baseD            = baseQ;
        addrD            = addrQ;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        memory_address   = addrQ;

        unique case (stateQ)
            StIdle: begin
                if (miss_detected) begin
                    baseD   = miss_address & AlignMask;
                    reqCntD = '0;
                    retCntD = '0;
                    stateD  = StFill;
                end
            end
            StFill: begin
                fsm_busy = 1'b1;
                // Base is line-aligned, so the offset add never carries out of the line.
                if (reqCntQ < CntW'(LINE_WORDS)) begin
                    mem_read_en    = 1'b1;
                    memory_address = baseQ + (ADDR_W'(reqCntQ) << 1);
                    addrD          = memory_address;
                    reqCntD        = reqCntQ + 1'b1;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    retCntD          = retCntQ + 1'b1;
                    if (retCntQ == CntW'(LINE_WORDS - 1)) begin
                        write_tag_array = 1'b1;
                        stateD          = StIdle;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign fill_word_index = retCntQ[IdxW-1:0];
    assign fill_data       = memory_data;
    assign fill_base_addr  = baseQ;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a memory model answers requests, stimulus pushes
// expected requests/writes/tags, and a negedge monitor pops and compares them.
module tb_cache_fill_fsm;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'h0;
    logic        write_data_array;
    logic [2:0]  fill_word_index;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic [15:0] fill_base_addr;

    cache_fill_fsm #(.LINE_WORDS(LW), .ADDR_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .fsm_busy         (fsm_busy),
        .mem_read_en      (mem_read_en),
        .memory_address   (memory_address),
        .memory_data_valid(memory_data_valid),
        .memory_data      (memory_data),
        .write_data_array (write_data_array),
        .fill_word_index  (fill_word_index),
        .fill_data        (fill_data),
        .write_tag_array  (write_tag_array),
        .fill_base_addr   (fill_base_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        int          idx;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;

    exp_t  reqQ[$];
    exp_t  wrQ[$];
    exp_t  tagQ[$];
    pend_t memQ[$];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;
    int writesSeen = 0;
    int reqSeen = 0;
    int lastDue = 0;
    bit spurious = 1'b0;
    bit irregular = 1'b0;
    bit monOn = 1'b0;
    bit checkIdleNext = 1'b0;
    int latTab[8] = '{2, 7, 3, 5, 2, 6, 4, 7};

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Memory model: returns word = address, in order, at most one per cycle.
    always @(posedge clk) begin
        pend_t p;
        cyc = cyc + 1;
        #1;
        if (spurious) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'hDEAD;
        end else if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            p                 = memQ.pop_front();
            memory_data_valid = 1'b1;
            memory_data       = p.addr;
        end else begin
            memory_data_valid = 1'b0;
            memory_data       = 16'h0;
        end
    end

    always @(negedge clk) begin
        exp_t  e;
        pend_t p;
        int    lat;
        if (mem_read_en === 1'b1) begin
            lat     = irregular ? latTab[reqSeen % 8] : 4;
            reqSeen = reqSeen + 1;
            p.addr  = memory_address;
            p.due   = cyc + lat;
            if (p.due <= lastDue) p.due = lastDue + 1;
            lastDue = p.due;
            memQ.push_back(p);
        end
        if (monOn && !rst) begin
            if (checkIdleNext) begin
                check("busy_after_tag", 32'(fsm_busy), 32'd0);
                checkIdleNext = 1'b0;
            end
            if (mem_read_en) begin
                if (reqQ.size() == 0) check("unexpected_req", 32'(mem_read_en), 32'd0);
                else begin
                    e = reqQ.pop_front();
                    check("req_addr", 32'(memory_address), 32'(e.val));
                    if (e.cyc >= 0) check("req_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (write_data_array) begin
                writesSeen = writesSeen + 1;
                if (wrQ.size() == 0) check("unexpected_write", 32'(write_data_array), 32'd0);
                else begin
                    e = wrQ.pop_front();
                    check("wr_index", 32'(fill_word_index), 32'(e.idx));
                    check("wr_data", 32'(fill_data), 32'(e.val));
                    if (e.cyc >= 0) check("wr_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (write_tag_array) begin
                if (tagQ.size() == 0) check("unexpected_tag", 32'(write_tag_array), 32'd0);
                else begin
                    e = tagQ.pop_front();
                    check("tag_base", 32'(fill_base_addr), 32'(e.val));
                    check("tag_with_write", 32'(write_data_array), 32'd1);
                    check("tag_last_index", 32'(fill_word_index), 32'(e.idx));
                    if (e.cyc >= 0) check("tag_cycle", 32'(cyc), 32'(e.cyc));
                    checkIdleNext = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expected timing assumes latency-4 memory: requests c0+1.., writes c0+5.., tag c0+12.
    task automatic expect_fill(input logic [15:0] missAddr, input int c0, input bit timed);
        exp_t        e;
        logic [15:0] base;
        base = missAddr & 16'hFFF0;
        for (int i = 0; i < LW; i++) begin
            e.val = base + 16'(2 * i);
            e.idx = i;
            e.cyc = timed ? c0 + 1 + i : -1;
            reqQ.push_back(e);
            e.cyc = timed ? c0 + 5 + i : -1;
            wrQ.push_back(e);
        end
        e.val = base;
        e.idx = LW - 1;
        e.cyc = timed ? c0 + 12 : -1;
        tagQ.push_back(e);
    endtask

    task automatic issue_miss(input logic [15:0] a, input bit timed);
        miss_detected = 1'b1;
        miss_address  = a;
        expect_fill(a, cyc, timed);
        tick();
        miss_detected = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((tagQ.size() != 0 || wrQ.size() != 0 || fsm_busy || memQ.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: got pending tags=%0d, want 0", name, tagQ.size());
            reqQ.delete();
            wrQ.delete();
            tagQ.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        int c0;
        int w0;
        int n;

        // 1: reset, then idle with spurious valids
        rst = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        monOn    = 1'b1;
        spurious = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(fsm_busy), 32'd0);
            check("idle_rd", 32'(mem_read_en), 32'd0);
            check("idle_wr", 32'(write_data_array), 32'd0);
            check("idle_tag", 32'(write_tag_array), 32'd0);
            check("idle_addr", 32'(memory_address), 32'h0);
            tick();
        end
        spurious = 1'b0;
        tick();

        // 2: basic fill, latency 4
        issue_miss(16'h1234, 1'b1);
        wait_done("t2");

        // 3: top-of-memory line, no wrap
        issue_miss(16'hFFFE, 1'b1);
        wait_done("t3");

        // 4: miss held through a fill, including its completion cycle
        c0            = cyc;
        miss_detected = 1'b1;
        miss_address  = 16'h1234;
        expect_fill(16'h1234, c0, 1'b1);
        tick();
        miss_address = 16'h4000;
        expect_fill(16'h4000, c0 + 13, 1'b1);
        while (cyc < c0 + 13) tick();
        tick();
        miss_detected = 1'b0;
        wait_done("t4");

        // 5: reset after the third returned word
        issue_miss(16'h1300, 1'b1);
        w0 = writesSeen;
        n  = 0;
        while (writesSeen < w0 + 3 && n < 50) begin
            tick();
            n++;
        end
        check("t5_three_writes", 32'(writesSeen - w0), 32'd3);
        rst = 1'b1;
        reqQ.delete();
        wrQ.delete();
        tagQ.delete();
        checkIdleNext = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy", 32'(fsm_busy), 32'd0);
        check("t5_tag", 32'(write_tag_array), 32'd0);
        check("t5_rd", 32'(mem_read_en), 32'd0);
        check("t5_addr", 32'(memory_address), 32'h0);
        tick();
        n = 0;
        while (memQ.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        issue_miss(16'h1302, 1'b1);
        wait_done("t5");

        // 6: irregular latency 2-7
        irregular = 1'b1;
        reqSeen   = 0;
        issue_miss(16'h5A5A, 1'b0);
        wait_done("t6");
        irregular = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling controller between the CPU's instruction/data caches and the shared multi-cycle main memory. On a cache miss it fetches the full 16-byte line, one word per request, and streams each returned word into the cache data array. It writes the tag when the last word lands. While it is busy the CPU front end stalls.

Parameters:
LINE_WORDS, 8, 16-bit words per cache line; must be a power of 2. Byte offset width is log2(2*LINE_WORDS).
ADDR_W, 16, byte-address width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
miss_detected  input  1  cache lookup missed this cycle
miss_address  input  ADDR_W  byte address of the missing access
fsm_busy  output  1  fill in progress; CPU stalls on miss_detected | fsm_busy
mem_read_en  output  1  read request to main memory this cycle
memory_address  output  ADDR_W  byte address of the current read request
memory_data_valid  input  1  memory returns one word this cycle, in request order
memory_data  input  16  returned word
write_data_array  output  1  write fill_data into the data array at fill_word_index
fill_word_index  output  log2(LINE_WORDS)  word slot within the line
fill_data  output  16  equals memory_data (combinational pass-through)
write_tag_array  output  1  write tag/valid for fill_base_addr
fill_base_addr  output  ADDR_W  line-aligned base address of the current fill

Behaviour:
- States: IDLE, FILL. fsm_busy = (state == FILL).
- Reset takes effect on the edge with rst=1:
  - state goes to IDLE; req_cnt, ret_cnt, fill_base_addr and memory_address all go to 0.
  - All strobes are low in the following cycle. Reset during a fill aborts it; no tag write occurs.
- IDLE:
  - All strobes are low. memory_data_valid is ignored.
  - If miss_detected=1 at the edge: latch fill_base_addr = miss_address with the low log2(2*LINE_WORDS) bits cleared (0xFFF0 mask for the default), clear both counters, and go to FILL.
- FILL, request side:
  - mem_read_en = (req_cnt < LINE_WORDS).
  - memory_address = fill_base_addr + 2*req_cnt.
  - req_cnt increments each cycle while mem_read_en=1, giving back-to-back requests.
  - Outside the request window, memory_address holds its last value.
- FILL, return side:
  - When memory_data_valid=1: write_data_array=1, fill_word_index=ret_cnt, and ret_cnt increments at the edge.
  - Memory latency is not counted internally; only memory_data_valid advances ret_cnt.
- Completion:
  - In the cycle where memory_data_valid=1 and ret_cnt=LINE_WORDS-1, both write_data_array and write_tag_array are 1 (single-cycle pulse).
  - Next state is IDLE, so fsm_busy drops the following cycle.
- Address arithmetic:
  - Offsets stay within the line; the sum never carries past the line because the base is aligned.
  - A miss at 0xFFFE fills 0xFFF0..0xFFFE with no wrap to 0x0000.
- Simultaneous events:
  - miss_detected while in FILL is ignored, including in the completion cycle. The CPU re-presents the miss next cycle, where it hits or starts a new fill.
  - memory_data_valid in the same cycle as a request is legal (latency 0 memory).
- Extra memory_data_valid after completion arrives in IDLE and is ignored.
- Counters are log2(LINE_WORDS)+1 bits wide. No overflow is possible because requests stop at LINE_WORDS.

Test Plan:
1. Reset, then idle 5 cycles with miss_detected=0 and spurious memory_data_valid=1 -> all strobes 0, fsm_busy=0, memory_address=0x0000.
2. Miss at 0x1234 in cycle 0; memory model has latency 4 and returns word = address:
   - Requests 0x1230..0x123E go out in cycles 1-8.
   - Writes with index 0..7 and data 0x1230..0x123E occur in cycles 5-12.
   - write_tag_array=1 only in cycle 12 with fill_base_addr=0x1230; fsm_busy=0 in cycle 13.
3. Miss at 0xFFFE -> fill_base_addr=0xFFF0; last request 0xFFFE; no address 0x0000 is ever driven.
4. New miss_detected=0x4000 held through a fill of 0x1230, including its completion cycle -> no effect during FILL. The 0x4000 fill starts the cycle after IDLE is re-entered, with first request 0x4000.
5. rst pulsed after the 3rd returned word of a fill -> next cycle fsm_busy=0, no write_tag_array. Remaining valids are ignored; a subsequent miss refills from index 0.
6. Memory with irregular valid gaps (latency 2-7 cycles) -> indices are written strictly 0..7 in order. Tag is written exactly once, on the 8th valid.
